d2d_demux: RTL and testbench



---
 rtl/d2d_pkg.sv | 14 +
 rtl/d2d_rx_fifo.sv | 62 ++++++
 rtl/d2d_demux.sv | 120 ++++++++++++
 tb/tb_d2d_demux.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/d2d_pkg.sv
// Shared definitions for the die-to-die link: flit control-bit offsets and the
// wormhole framing state, used by both the transmit arbiter and the receive demux.
package d2d_pkg;

  // Control bits sit at FLIT_WIDTH - offset (head is the MSB, tail just below it).
  localparam int unsigned HEAD_BIT = 1;
  localparam int unsigned TAIL_BIT = 2;

  typedef enum logic {
    FrmIdle  = 1'b0,
    FrmInPkt = 1'b1
  } frame_state_e;

endpackage

// File: rtl/d2d_rx_fifo.sv
// Single-channel receive FIFO. Storage is reset so the head flit reads 0 after
// reset; a push into a full FIFO is only taken when a pop frees the slot.
module d2d_rx_fifo #(
  parameter int unsigned FLIT_WIDTH = 66,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [FLIT_WIDTH-1:0]      push_data,
  input  logic                       pop,
  output logic [FLIT_WIDTH-1:0]      pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [FLIT_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           count_q, count_d;
  logic                  do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

endmodule

// File: rtl/d2d_demux.sv
// Far-die receive side of the D2D link: steers tagged flits into per-channel
// FIFOs, returns one credit per drained flit and checks per-channel framing.
module d2d_demux
  import d2d_pkg::*;
#(
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned FLIT_WIDTH = 66,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           link_valid,
  input  logic [$clog2(CHANNELS)-1:0]    link_channel,
  input  logic [FLIT_WIDTH-1:0]          link_data,
  output logic [CHANNELS-1:0]            out_valid,
  output logic [CHANNELS*FLIT_WIDTH-1:0] out_data,
  input  logic [CHANNELS-1:0]            out_ready,
  output logic [CHANNELS-1:0]            credit_return,
  output logic                           overflow_err,
  output logic                           framing_err,
  output logic [$clog2(CHANNELS)-1:0]    err_channel
);

  localparam int unsigned CW   = $clog2(CHANNELS);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic                head, tail, chan_ok;
  logic [CHANNELS-1:0] pop, accept, overrun, frm_bad;
  logic [CHANNELS-1:0] credit_q;
  logic                overflow_q, overflow_d;
  logic                framing_q, framing_d;
  logic [CW-1:0]       err_channel_q, err_channel_d;
  logic                ovf_new, frm_new;
  frame_state_e        frm_q [CHANNELS];
  frame_state_e        frm_d [CHANNELS];

  assign head    = link_data[FLIT_WIDTH-HEAD_BIT];
  assign tail    = link_data[FLIT_WIDTH-TAIL_BIT];
  assign chan_ok = int'(link_channel) < int'(CHANNELS);

  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
    logic                  push_req, full, empty;
    logic [CntW-1:0]       count;
    logic [FLIT_WIDTH-1:0] head_data;

    assign push_req   = link_valid & chan_ok & (link_channel == CW'(i));
    assign pop[i]     = ~empty & out_ready[i];
    // A full FIFO still takes the flit when its head leaves in the same cycle.
    assign accept[i]  = push_req & ((count < CntW'(DEPTH)) | pop[i]);
    assign overrun[i] = push_req & full & ~pop[i];

    d2d_rx_fifo #(
      .FLIT_WIDTH(FLIT_WIDTH),
      .DEPTH     (DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rstn     (rstn),
      .push     (accept[i]),
      .push_data(link_data),
      .pop      (pop[i]),
      .pop_data (head_data),
      .count    (count),
      .full     (full),
      .empty    (empty)
    );

    assign out_valid[i]                       = ~empty;
    assign out_data[i*FLIT_WIDTH +: FLIT_WIDTH] = head_data;
  end

  // Bad sequences still update state from the tail bit so framing resynchronises.
  always_comb begin
    for (int i = 0; i < int'(CHANNELS); i++) begin
      frm_d[i]   = frm_q[i];
      frm_bad[i] = 1'b0;
      if (accept[i]) begin
        frm_d[i]   = tail ? FrmIdle : FrmInPkt;
        frm_bad[i] = (frm_q[i] == FrmIdle) ? ~head : head;
      end
    end
  end

  assign ovf_new = |overrun;
  assign frm_new = (|frm_bad) | (link_valid & ~chan_ok);

  always_comb begin
    overflow_d    = overflow_q | ovf_new;
    framing_d     = framing_q | frm_new;
    err_channel_d = err_channel_q;
    if ((ovf_new | frm_new) & ~(overflow_q | framing_q)) begin
      err_channel_d = link_channel;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      credit_q      <= '0;
      overflow_q    <= 1'b0;
      framing_q     <= 1'b0;
      err_channel_q <= '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        frm_q[i] <= FrmIdle;
      end
    end else begin
      credit_q      <= pop;
      overflow_q    <= overflow_d;
      framing_q     <= framing_d;
      err_channel_q <= err_channel_d;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        frm_q[i] <= frm_d[i];
      end
    end
  end

  assign credit_return = credit_q;
  assign overflow_err  = overflow_q;
  assign framing_err   = framing_q;
  assign err_channel   = err_channel_q;

endmodule

// File: tb/tb_d2d_demux.sv
// Directed bench for d2d_demux: a vector table for single-flit and interleaved
// traffic, then hand sequences for overflow, framing, async reset and full+pop.
module tb_d2d_demux;

  logic         clk = 1'b0;
  logic         rstn;
  logic         link_valid;
  logic [0:0]   link_channel;
  logic [65:0]  link_data;
  logic [1:0]   out_valid;
  logic [131:0] out_data;
  logic [1:0]   out_ready;
  logic [1:0]   credit_return;
  logic         overflow_err;
  logic         framing_err;
  logic [0:0]   err_channel;

  int total = 0;
  int bad   = 0;

  d2d_demux #(
    .CHANNELS  (2),
    .FLIT_WIDTH(66),
    .DEPTH     (4)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .link_valid   (link_valid),
    .link_channel (link_channel),
    .link_data    (link_data),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .credit_return(credit_return),
    .overflow_err (overflow_err),
    .framing_err  (framing_err),
    .err_channel  (err_channel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        lv;
    logic        ch;
    logic [65:0] d;
    logic [1:0]  rdy;
    logic [1:0]  ov;
    logic [65:0] od0;
    logic [65:0] od1;
    logic [1:0]  cr;
  } vec_t;

  function automatic logic [65:0] mk(input logic h, input logic t, input logic [63:0] p);
    return {h, t, p};
  endfunction

  function automatic vec_t mkv(input logic lv, input logic ch, input logic [65:0] d,
                               input logic [1:0] rdy, input logic [1:0] ov,
                               input logic [65:0] od0, input logic [65:0] od1,
                               input logic [1:0] cr);
    vec_t v;
    v.lv = lv; v.ch = ch; v.d = d; v.rdy = rdy;
    v.ov = ov; v.od0 = od0; v.od1 = od1; v.cr = cr;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic lv, input logic ch, input logic [65:0] d,
                       input logic [1:0] rdy);
    link_valid   = lv;
    link_channel = ch;
    link_data    = d;
    out_ready    = rdy;
  endtask

  vec_t        vecs [12];
  logic [65:0] s, a0, a1, a2, b0, b1, b2, x, bd, r0, r1, h;
  logic [65:0] f [4];
  logic [65:0] g [4];
  int          ncred;

  initial begin
    s  = mk(1'b1, 1'b1, 64'h5151);
    a0 = mk(1'b1, 1'b0, 64'hA0); a1 = mk(1'b0, 1'b0, 64'hA1); a2 = mk(1'b0, 1'b1, 64'hA2);
    b0 = mk(1'b1, 1'b0, 64'hB0); b1 = mk(1'b0, 1'b0, 64'hB1); b2 = mk(1'b0, 1'b1, 64'hB2);
    f[0] = mk(1'b1, 1'b0, 64'hF0); f[1] = mk(1'b0, 1'b0, 64'hF1);
    f[2] = mk(1'b0, 1'b0, 64'hF2); f[3] = mk(1'b0, 1'b1, 64'hF3);
    x  = mk(1'b1, 1'b1, 64'hDEAD);
    bd = mk(1'b0, 1'b0, 64'hB0D1);
    r0 = mk(1'b1, 1'b0, 64'h70); r1 = mk(1'b0, 1'b0, 64'h71);
    h  = mk(1'b1, 1'b1, 64'h4EAD);
    g[0] = mk(1'b1, 1'b0, 64'h60); g[1] = mk(1'b0, 1'b0, 64'h61);
    g[2] = mk(1'b0, 1'b0, 64'h62); g[3] = mk(1'b0, 1'b1, 64'h63);

    // Outputs observed just after the edge that consumed the inputs.
    vecs[0]  = mkv(1'b0, 1'b0, '0, 2'b00, 2'b00, '0, '0, 2'b00);
    vecs[1]  = mkv(1'b1, 1'b1, s,  2'b00, 2'b10, '0, s,  2'b00);
    vecs[2]  = mkv(1'b0, 1'b0, '0, 2'b10, 2'b00, '0, '0, 2'b10);
    vecs[3]  = mkv(1'b0, 1'b0, '0, 2'b00, 2'b00, '0, '0, 2'b00);
    vecs[4]  = mkv(1'b1, 1'b0, a0, 2'b11, 2'b01, a0, '0, 2'b00);
    vecs[5]  = mkv(1'b1, 1'b1, b0, 2'b11, 2'b10, '0, b0, 2'b01);
    vecs[6]  = mkv(1'b1, 1'b0, a1, 2'b11, 2'b01, a1, '0, 2'b10);
    vecs[7]  = mkv(1'b1, 1'b1, b1, 2'b11, 2'b10, '0, b1, 2'b01);
    vecs[8]  = mkv(1'b1, 1'b0, a2, 2'b11, 2'b01, a2, '0, 2'b10);
    vecs[9]  = mkv(1'b1, 1'b1, b2, 2'b11, 2'b10, '0, b2, 2'b01);
    vecs[10] = mkv(1'b0, 1'b0, '0, 2'b11, 2'b00, '0, '0, 2'b10);
    vecs[11] = mkv(1'b0, 1'b0, '0, 2'b11, 2'b00, '0, '0, 2'b00);

    rstn = 1'b0;
    drive(1'b0, 1'b0, '0, 2'b00);
    #3;
    check("reset out_valid", out_valid, 2'b00);
    check("reset credit", credit_return, 2'b00);
    check("reset errors", {overflow_err, framing_err, err_channel}, 3'b000);
    check("reset out_data", out_data, '0);
    #9;
    rstn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].lv, vecs[i].ch, vecs[i].d, vecs[i].rdy);
      step();
      check($sformatf("v%0d out_valid", i), out_valid, vecs[i].ov);
      check($sformatf("v%0d credit", i), credit_return, vecs[i].cr);
      check($sformatf("v%0d errors", i), {overflow_err, framing_err}, 2'b00);
      if (vecs[i].ov[0]) check($sformatf("v%0d data0", i), out_data[65:0], vecs[i].od0);
      if (vecs[i].ov[1]) check($sformatf("v%0d data1", i), out_data[131:66], vecs[i].od1);
    end

    // Fill channel 0, then overrun it with a fifth flit.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, f[k], 2'b00);
      step();
    end
    check("fill valid", out_valid, 2'b01);
    drive(1'b1, 1'b0, x, 2'b00);
    step();
    check("overflow flag", overflow_err, 1'b1);
    check("overflow err_channel", err_channel, 1'b0);
    check("overflow no framing", framing_err, 1'b0);
    ncred = 0;
    drive(1'b0, 1'b0, '0, 2'b01);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain order %0d", k), out_data[65:0], f[k]);
      step();
      ncred += int'(credit_return[0]);
    end
    drive(1'b0, 1'b0, '0, 2'b00);
    step();
    ncred += int'(credit_return[0]);
    check("drain credits", ncred, 4);
    check("dropped flit absent", out_valid, 2'b00);

    // Body flit on idle channel 1 after the channel-0 overflow.
    drive(1'b1, 1'b1, bd, 2'b00);
    step();
    check("framing flag", framing_err, 1'b1);
    check("framing keeps err_channel", err_channel, 1'b0);
    check("framing flit delivered", out_valid, 2'b10);
    check("framing flit data", out_data[131:66], bd);

    // Asynchronous reset with a partial packet buffered.
    drive(1'b1, 1'b0, r0, 2'b00);
    step();
    drive(1'b1, 1'b0, r1, 2'b00);
    step();
    drive(1'b0, 1'b0, '0, 2'b00);
    #2;
    rstn = 1'b0;
    #1;
    check("async reset valid", out_valid, 2'b00);
    check("async reset credit", credit_return, 2'b00);
    check("async reset errors", {overflow_err, framing_err, err_channel}, 3'b000);
    check("async reset data", out_data, '0);
    #2;
    rstn = 1'b1;
    drive(1'b1, 1'b0, h, 2'b00);
    step();
    check("post-reset head no error", framing_err, 1'b0);
    check("post-reset head valid", out_valid, 2'b01);
    check("post-reset head data", out_data[65:0], h);
    check("post-reset no credit", credit_return, 2'b00);

    // Fill to DEPTH, then push and pop in the same cycle.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, g[k], 2'b00);
      step();
    end
    drive(1'b1, 1'b0, g[3], 2'b01);
    step();
    check("full push+pop no overflow", overflow_err, 1'b0);
    check("full push+pop credit", credit_return, 2'b01);
    ncred = 0;
    drive(1'b0, 1'b0, '0, 2'b01);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("full drain order %0d", k), out_data[65:0], g[k]);
      step();
      ncred += int'(credit_return[0]);
    end
    check("full drain credits", ncred, 4);
    check("full drain empty", out_valid, 2'b00);
    drive(1'b0, 1'b0, '0, 2'b00);
    step();
    check("no extra credit", credit_return, 2'b00);
    check("final errors clear", {overflow_err, framing_err}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
